// File: rtl/plic_lite.sv
// plic_lite: AHB-Lite platform interrupt controller with priority arbitration and claim/complete
module plic_lite #(
  parameter int NUM_SRC = 4,
  parameter int PRIO_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               HSELx,
  input  logic [31:0]        HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [1:0]         HTRANS,
  input  logic               HMASTLOCK,
  input  logic [31:0]        HWDATA,
  output logic [31:0]        HRDATA,
  output logic               HREADY,
  output logic [1:0]         HRESP,
  output logic               irq_external
);
  localparam logic [5:0] A_PEND = 6'h20, A_EN = 6'h21, A_TH = 6'h22, A_CLAIM = 6'h23;
  logic [PRIO_WIDTH-1:0] prio [1:NUM_SRC];
  logic [NUM_SRC:1] pending, inflight, enable;
  logic [PRIO_WIDTH-1:0] threshold, best_prio;
  logic [4:0] best_id;
  logic [5:0] dp_addr;
  logic dp_valid, dp_write, rd_phase, wr_phase, claim, complete;
  logic unused;
  assign unused = ^{HSIZE, HBURST, HMASTLOCK, HADDR[31:8], HADDR[1:0], HWDATA};
  assign HREADY = 1'b1;
  assign HRESP = 2'b00;
  assign rd_phase = rst_n && dp_valid && !dp_write;
  assign wr_phase = dp_valid && dp_write;
  assign claim = rd_phase && dp_addr == A_CLAIM && best_id != 5'd0;
  assign complete = wr_phase && dp_addr == A_CLAIM;
  // strict > keeps the lowest ID on priority ties
  always_comb begin
    best_id = '0;
    best_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++)
      if (pending[i] && enable[i] && prio[i] > threshold && prio[i] > best_prio) begin
        best_id = 5'(i);
        best_prio = prio[i];
      end
  end
  always_comb begin
    HRDATA = '0;
    for (int i = 1; i <= NUM_SRC; i++)
      if (rd_phase && dp_addr == 6'(i)) HRDATA = 32'(prio[i]);
    if (rd_phase)
      HRDATA = dp_addr == A_PEND  ? 32'({pending, 1'b0}) :
               dp_addr == A_EN    ? 32'({enable, 1'b0}) :
               dp_addr == A_TH    ? 32'(threshold) :
               dp_addr == A_CLAIM ? 32'(best_id) : HRDATA;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr <= '0;
      pending <= '0;
      inflight <= '0;
      enable <= '0;
      threshold <= '0;
      irq_external <= 1'b0;
      for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
    end else begin
      dp_valid <= HSELx && HTRANS[1];
      dp_write <= HWRITE;
      dp_addr <= HADDR[7:2];
      irq_external <= best_id != 5'd0;
      if (wr_phase && dp_addr == A_EN) enable <= HWDATA[NUM_SRC:1];
      if (wr_phase && dp_addr == A_TH) threshold <= HWDATA[PRIO_WIDTH-1:0];
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (wr_phase && dp_addr == 6'(i)) prio[i] <= HWDATA[PRIO_WIDTH-1:0];
        pending[i] <= pending[i] ? !(claim && best_id == 5'(i)) : irq_src[i-1] && !inflight[i];
        inflight[i] <= (claim && best_id == 5'(i)) ? 1'b1 :
                       (complete && HWDATA[4:0] == 5'(i)) ? 1'b0 : inflight[i];
      end
    end
  end
endmodule
